clk_div_monitor: RTL

- Receiving-end checker for the cascaded clock divider outputs (div2/div4/div8/div16 and their AND combinations).
- Samples one divided-clock waveform in the `clk` domain and measures period and high time in `clk` cycles.
- Declares lock once the period is stable, reports the divide ratio as log2 when it is a power of two, and flags a stalled input.
- Sits beside the divider so silicon and bench can self-check divider ratios without a scope.

---
 rtl/clk_div_monitor_if.sv | 30 +++
 rtl/clk_div_monitor.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/clk_div_monitor_if.sv
// clk_div_monitor_if
//   Bundles the waveform under test and the measurement results of
//   clk_div_monitor.
//   master : drives div_in, observes results (divider side / bench)
//   slave  : samples div_in, produces results (the monitor)
//   Signals: div_in, period, high_time, meas_valid, locked, pow2,
//            ratio_log2, duty50, timeout
interface clk_div_monitor_if #(
  parameter int CNT_W = 8
);
  logic             div_in;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             meas_valid;
  logic             locked;
  logic             pow2;
  logic [3:0]       ratio_log2;
  logic             duty50;
  logic             timeout;

  modport master (
    output div_in,
    input  period, high_time, meas_valid, locked, pow2, ratio_log2, duty50, timeout
  );

  modport slave (
    input  div_in,
    output period, high_time, meas_valid, locked, pow2, ratio_log2, duty50, timeout
  );
endinterface

// File: rtl/clk_div_monitor.sv
// clk_div_monitor
//   Measures period and high time (in clk cycles) of an asynchronous
//   divided-clock waveform, declares lock once the period repeats
//   LOCK_COUNT times, reports power-of-two ratios and flags a stalled input.
//   Ports:
//     clk   : system clock, rising edge
//     rst_n : async active-low reset, release synchronised by two flops
//     mon   : clk_div_monitor_if.slave (div_in in, measurement results out)
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ST_IDLE    | waiting for first rise (after reset or timeout); no output
//   ST_MEASURE | measuring periods, not yet stable
//   ST_LOCKED  | last LOCK_COUNT periods identical
module clk_div_monitor #(
  parameter int CNT_W      = 8,
  parameter int LOCK_COUNT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  clk_div_monitor_if.slave  mon
);

  typedef enum logic [1:0] {ST_IDLE, ST_MEASURE, ST_LOCKED} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [3:0]       LOCK_N  = 4'(LOCK_COUNT);

  logic [1:0]       r_rst_sync;
  logic             w_rst_n;
  logic             r_s1, r_s2, r_s3;
  logic             w_rise, w_fall;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [CNT_W-1:0] r_period, r_high;
  logic [3:0]       r_same, w_same_next;
  logic             r_meas_valid, r_timeout;
  logic             w_active, w_to;
  logic             w_pow2, w_duty50;
  logic [3:0]       w_log2;
  state_t           r_state, w_state_next;

  // Assertion is immediate; release waits two clocks so every flop below
  // leaves reset on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rst_sync <= 2'b00;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= mon.div_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_rise    = r_s2 & ~r_s3;
  assign w_fall    = ~r_s2 & r_s3;
  assign w_cnt_inc = r_cnt + CNT_ONE;   // wraps to 0 for a 2^CNT_W period
  assign w_active  = (r_state != ST_IDLE);
  // A rise on the saturating cycle is still a valid (wrapped) measurement.
  assign w_to      = w_active && !w_rise && (r_cnt == CNT_MAX);

  always_comb begin
    w_same_next = 4'd1;
    if (w_cnt_inc == r_period)
      w_same_next = (r_same >= LOCK_N) ? LOCK_N : r_same + 4'd1;
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_rise) w_state_next = ST_MEASURE;
      end
      ST_MEASURE, ST_LOCKED: begin
        if (w_rise)    w_state_next = (w_same_next == LOCK_N) ? ST_LOCKED : ST_MEASURE;
        else if (w_to) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_cnt        <= '0;
      r_period     <= '0;
      r_high       <= '0;
      r_same       <= '0;
      r_meas_valid <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_meas_valid <= 1'b0;

      if (w_rise)                r_cnt <= '0;
      else if (r_cnt != CNT_MAX) r_cnt <= w_cnt_inc;

      if (w_active && w_rise) begin
        r_period     <= w_cnt_inc;
        r_same       <= w_same_next;
        r_meas_valid <= 1'b1;
      end else if (w_to) begin
        r_same <= '0;
      end

      if (w_active && w_fall) r_high <= w_cnt_inc;

      if (w_rise)    r_timeout <= 1'b0;
      else if (w_to) r_timeout <= 1'b1;
    end
  end

  always_comb begin
    w_pow2 = (r_period != '0) && ((r_period & (r_period - CNT_ONE)) == '0);
    w_log2 = 4'd0;
    if (w_pow2) begin
      for (int i = 0; i < CNT_W; i++) begin
        if (r_period[i]) w_log2 = 4'(i);
      end
    end
  end

  // Gated on a nonzero period so the reset value reads 0.
  assign w_duty50 = (r_period != '0) && ({r_high, 1'b0} == {1'b0, r_period});

  assign mon.period     = r_period;
  assign mon.high_time  = r_high;
  assign mon.meas_valid = r_meas_valid;
  assign mon.locked     = (r_state == ST_LOCKED);
  assign mon.pow2       = w_pow2;
  assign mon.ratio_log2 = w_log2;
  assign mon.duty50     = w_duty50;
  assign mon.timeout    = r_timeout;

endmodule
